// File: rtl/dc_fifo_pkg.sv
// Shared definitions for the dual-clock toggle FIFO read and write sides.
// Both sides use the same synchronizer depth and slot-index wrap.
package dc_fifo_pkg;

  localparam int DC_SYNC_STAGES = 2;

  // Wraps explicitly, so the depth does not have to be a power of two.
  function automatic int slot_idx_next(input int idx, input int depth);
    return (idx >= depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dc_sync_2ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
module dc_sync_2ff
  import dc_fifo_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DC_SYNC_STAGES-1:0] sync_q;
  logic [DC_SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DC_SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[DC_SYNC_STAGES-1];

endmodule

// File: rtl/dc_toggle_fifo_dout.sv
// Read side of a dual-clock toggle-token slot FIFO: synchronizes the writer's
// per-slot tokens, reads slots strictly in order, and drives a registered stream.
module dc_toggle_fifo_dout
  import dc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [BUFFER_DEPTH-1:0]            write_token_i,
  input  logic [DATA_WIDTH*BUFFER_DEPTH-1:0] data_async_i,
  output logic [BUFFER_DEPTH-1:0]            read_pointer_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o
);

  localparam int IDX_W = $clog2(BUFFER_DEPTH);

  logic [BUFFER_DEPTH-1:0] wtok_s;
  logic [BUFFER_DEPTH-1:0] full;
  logic [DATA_WIDTH-1:0]   slot_data [BUFFER_DEPTH];

  logic [BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    load;

  for (genvar i = 0; i < BUFFER_DEPTH; i++) begin : g_slot
    dc_sync_2ff u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (write_token_i[i]),
      .q_o   (wtok_s[i])
    );
    assign slot_data[i] = data_async_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Slot data is only sampled once the synchronized token marks it full,
  // so the data bus itself is stable by then and needs no synchronizer.
  assign full = wtok_s ^ rd_ptr_q;

  // Stream handshake: a beat transfers on a rising edge where valid_o && ready_i;
  // once raised, valid_o and data_o stay stable until that transfer happens.
  assign load = full[rd_idx_q] && (!valid_q || ready_i);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    rd_idx_d = rd_idx_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load) begin
      data_d             = slot_data[rd_idx_q];
      valid_d            = 1'b1;
      rd_ptr_d[rd_idx_q] = ~rd_ptr_q[rd_idx_q];
      rd_idx_d           = IDX_W'(slot_idx_next(int'(rd_idx_q), BUFFER_DEPTH));
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      rd_idx_q <= rd_idx_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign read_pointer_o = rd_ptr_q;
  assign valid_o        = valid_q;
  assign data_o         = data_q;

endmodule

// File: tb/tb_dc_toggle_fifo_dout.sv
// Bench for dc_toggle_fifo_dout: the bench plays the writer and compares the
// stream against an in-order arrival-queue model every cycle.
module tb_dc_toggle_fifo_dout;

  localparam int W = 64;
  localparam int D = 8;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic [D-1:0]   write_token_i = '0;
  logic [W*D-1:0] data_async_i = '0;
  logic [D-1:0]   read_pointer_o;
  logic           valid_o;
  logic           ready_i = 1'b0;
  logic [W-1:0]   data_o;

  always #5 clk = ~clk;

  dc_toggle_fifo_dout #(.DATA_WIDTH(W), .BUFFER_DEPTH(D)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .write_token_i  (write_token_i),
    .data_async_i   (data_async_i),
    .read_pointer_o (read_pointer_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_o         (data_o)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];   // written payloads not yet read, in write order
  int           wcyc_q[$];  // cycle stamp at which each was written
  int           cyc = 0;
  int           wr_count = 0;
  int           rd_count = 0;
  logic         valid_m = 1'b0;
  logic [W-1:0] data_m = '0;

  // A write becomes readable three edges after the cycle it was driven in.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      valid_m  = 1'b0;
      data_m   = '0;
      rd_count = 0;
    end else begin
      cyc = cyc + 1;
      if (exp_q.size() > 0 && wcyc_q[0] + 3 <= cyc && (!valid_m || ready_i)) begin
        data_m  = exp_q.pop_front();
        void'(wcyc_q.pop_front());
        valid_m = 1'b1;
        rd_count++;
      end else if (valid_m && ready_i) begin
        valid_m = 1'b0;
      end
    end
  end

  function automatic logic [D-1:0] exp_rptr(input int reads);
    logic [D-1:0] r;
    for (int i = 0; i < D; i++) begin
      int n;
      n = reads / D + ((i < reads % D) ? 1 : 0);
      r[i] = n[0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_i) begin
      checks++;
      if (valid_o !== valid_m) begin
        errors++;
        $display("FAIL cyc_valid @%0d: got %b expected %b", cyc, valid_o, valid_m);
      end
      if (valid_m) begin
        checks++;
        if (data_o !== data_m) begin
          errors++;
          $display("FAIL cyc_data @%0d: got %h expected %h", cyc, data_o, data_m);
        end
      end
      checks++;
      if (read_pointer_o !== exp_rptr(rd_count)) begin
        errors++;
        $display("FAIL cyc_rptr @%0d: got %h expected %h", cyc, read_pointer_o,
                 exp_rptr(rd_count));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    write_token_i = '0;
    data_async_i  = '0;
    ready_i       = 1'b0;
    exp_q.delete();
    wcyc_q.delete();
    wr_count      = 0;
    step(3);
    rst_i = 1'b0;
  endtask

  // Writer side: fill the next slot in order and toggle its token.
  task automatic do_write(input logic [W-1:0] payload);
    int slot;
    slot = wr_count % D;
    data_async_i[slot*W +: W] = payload;
    write_token_i[slot]       = ~write_token_i[slot];
    exp_q.push_back(payload);
    wcyc_q.push_back(cyc);
    wr_count++;
  endtask

  function automatic logic [W-1:0] rand_payload();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] p0, p1, pn;
    int           budget;

    step(1);
    chk("reset_valid", W'(valid_o), W'(0));
    chk("reset_data", data_o, W'(0));
    chk("reset_rptr", W'(read_pointer_o), W'(0));
    do_reset();

    // single write, first-item latency
    ready_i = 1'b1;
    do_write(64'hDEAD_BEEF_0000_0001);
    step();
    @(negedge clk); chk("lat_edge1_valid", W'(valid_o), W'(0));
    step();
    @(negedge clk); chk("lat_edge2_valid", W'(valid_o), W'(0));
    step();
    @(negedge clk);
    chk("lat_edge3_valid", W'(valid_o), W'(1));
    chk("lat_edge3_data", data_o, 64'hDEAD_BEEF_0000_0001);
    chk("lat_edge3_rptr", W'(read_pointer_o), W'(8'h01));
    step(3);

    // full buffer with ready low, then drain
    do_reset();
    p0 = rand_payload();
    do_write(p0);
    for (int i = 1; i < D; i++) begin
      step();
      do_write(rand_payload());
    end
    step(12);
    @(negedge clk);
    chk("full_hold_valid", W'(valid_o), W'(1));
    chk("full_hold_data", data_o, p0);
    chk("full_hold_rptr", W'(read_pointer_o), W'(8'h01));
    ready_i = 1'b1;
    step(12);
    chk("full_drain_rptr", W'(read_pointer_o), W'(8'hFF));
    chk("full_drain_valid", W'(valid_o), W'(0));

    // 20 writes, random ready and gaps, wraps twice
    do_reset();
    budget = 0;
    while (wr_count < 20 && budget < 2000) begin
      ready_i = 1'($urandom_range(0, 1));
      if (wr_count - rd_count < D && $urandom_range(0, 3) != 0) do_write(rand_payload());
      step();
      budget++;
    end
    chk("rand_writes_done", W'(wr_count), W'(20));
    ready_i = 1'b1;
    step(20);
    chk("rand_rptr", W'(read_pointer_o), W'(8'h0F));
    chk("rand_model_reads", W'(rd_count), W'(20));
    chk("rand_queue_empty", W'(exp_q.size()), W'(0));

    // accept on the same edge the next slot becomes full
    do_reset();
    ready_i = 1'b1;
    p0 = 64'h1111_2222_3333_4444;
    p1 = 64'h5555_6666_7777_8888;
    do_write(p0);
    step();
    do_write(p1);
    step();
    @(negedge clk); chk("nobub_pre_valid", W'(valid_o), W'(0));
    step();
    @(negedge clk);
    chk("nobub_first_valid", W'(valid_o), W'(1));
    chk("nobub_first_data", data_o, p0);
    step();
    @(negedge clk);
    chk("nobub_second_valid", W'(valid_o), W'(1));
    chk("nobub_second_data", data_o, p1);
    step();
    @(negedge clk);
    chk("nobub_empty_valid", W'(valid_o), W'(0));
    chk("nobub_rptr", W'(read_pointer_o), W'(8'h03));

    // out-of-order token on slot 3 must not be bypassed
    do_reset();
    ready_i = 1'b1;
    data_async_i[3*W +: W] = 64'hBAD0_BAD0_BAD0_BAD0;
    write_token_i[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("bypass_valid", W'(valid_o), W'(0));
    end
    chk("bypass_rptr", W'(read_pointer_o), W'(0));

    // asynchronous reset mid-stream with items pending
    do_reset();
    ready_i = 1'b0;
    p0 = rand_payload();
    do_write(p0);
    step(); do_write(rand_payload());
    step(); do_write(rand_payload());
    step(5);
    chk("midrst_pre_valid", W'(valid_o), W'(1));
    chk("midrst_pre_data", data_o, p0);
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", W'(valid_o), W'(0));
    chk("midrst_data", data_o, W'(0));
    chk("midrst_rptr", W'(read_pointer_o), W'(0));
    do_reset();
    ready_i = 1'b1;
    pn = rand_payload();
    do_write(pn);
    step(3);
    @(negedge clk);
    chk("postrst_valid", W'(valid_o), W'(1));
    chk("postrst_data", data_o, pn);
    chk("postrst_rptr", W'(read_pointer_o), W'(8'h01));
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dc_toggle_fifo_dout.md
# dc_toggle_fifo_dout

Read side of one dual-clock AXI channel: consumes an asynchronous slot buffer (per-slot write-token bits plus flattened slot data) crossing in from the other clock domain through the input level-shifter wrapper. Emits a registered valid/ready stream in the local clock domain and returns per-slot read-pointer bits to the writer. One instance is used per AXI channel (AW, AR, W toward the SoC side; B, R toward the cluster side), with DATA_WIDTH set to the packed channel payload.

## Interface
Parameters:
- DATA_WIDTH, 64, packed payload width of one slot.
- BUFFER_DEPTH, 8, number of slots; must be ≥ 2; need not be a power of two.

Ports:
- clk_i  in  1  local clock.
- rst_i  in  1  reset, asynchronous, active-high; the block has one clock.
- write_token_i  in  BUFFER_DEPTH  writer-domain toggle bits; bit i toggles once per write into slot i.
- data_async_i  in  DATA_WIDTH*BUFFER_DEPTH  slot data; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- read_pointer_o  out  BUFFER_DEPTH  reader toggle bits; bit i toggles once per read of slot i.
- valid_o  out  1  output payload valid.
- ready_i  in  1  downstream accept.
- data_o  out  DATA_WIDTH  output payload.

## Operation
- Each write_token_i bit passes through a 2-flop synchronizer; the result is wtok_s.
- Slot i is full when wtok_s[i] != read_pointer_o[i].
- rd_idx holds the next slot to read. It has width $clog2(BUFFER_DEPTH), counts 0..BUFFER_DEPTH-1, and wraps explicitly to 0.
- Output register: valid_o/data_o.
  - load = full[rd_idx] && (!valid_o || ready_i).
  - On load:
    - data_o <= slot[rd_idx]
    - valid_o <= 1
    - read_pointer_o[rd_idx] toggles
    - rd_idx advances
  - When valid_o && ready_i && !full[rd_idx]: valid_o <= 0 and data_o holds its value.
- The block relies on the writer only toggling a token after that slot's data is stable. Data is sampled only after the synchronized token shows the slot full, so data_async_i needs no synchronizer.
- Slots are read strictly in order. Only rd_idx is examined; a full slot elsewhere never bypasses it.
- No two read_pointer_o bits toggle in the same cycle.

## Timing
- Reset values: read_pointer_o = 0, valid_o = 0, data_o = 0, rd_idx = 0, synchronizer flops = 0.
- Latency, with the output empty: write_token_i toggle sampled at edge 0 → wtok_s updates at edge 2 → valid_o high after edge 3.
- read_pointer_o toggles at the same edge at which valid_o rises for that slot.
- Throughput: one item per cycle while slots stay full and ready_i stays high.
- Output hold: while valid_o && !ready_i, data_o and valid_o are stable and rd_idx does not advance.
- Full buffer: all BUFFER_DEPTH slots full is legal. The writer blocks on its own side and this block needs no special case.
- Empty buffer: valid_o drops in the cycle after the last accept.
- Wrap-around: after slot BUFFER_DEPTH-1, rd_idx returns to 0. A toggle bit that returns to equality with wtok_s means that slot is empty again.
- Simultaneous accept and new slot full: load wins. valid_o stays 1 and data_o updates with no bubble.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. Writer and reader must be reset together; a one-sided reset is unsupported.

## Structure
- Shared package dc_fifo_pkg:
  - DC_SYNC_STAGES = 2.
  - Function slot_idx_next(idx, depth) implementing the wrap.
  - Shared with the matching write-side block.
- One sub-module: dc_sync_2ff (single-bit, async active-high reset to 0), instantiated BUFFER_DEPTH times.
- Everything else is flat in the top module.

## Test plan
- Reset, then 1 write with 0xDEAD_BEEF_0000_0001 in slot 0 (toggle write_token_i[0]), ready_i = 1 → valid_o rises after 3 edges with that data; read_pointer_o = 8'h01.
- 8 writes back-to-back, ready_i held low → valid_o = 1 with slot 0 data held stable; read_pointer_o = 8'h01. Then raise ready_i → 7 further items, one per cycle, in slot order; final read_pointer_o = 8'hFF.
- 20 writes, BUFFER_DEPTH = 8, with rd_idx wrapping twice and random ready_i → all 20 payloads in order, no duplicates or drops; read_pointer_o = 8'h0F at the end (slots 0–3 toggled three times, slots 4–7 twice).
- Accept on the same edge a new slot becomes full → valid_o stays 1 with no bubble; data_o changes to the next payload.
- Toggle write_token_i[3] while rd_idx = 0 and slot 0 is empty → valid_o stays 0; slot 3 is not bypassed.
- Assert rst_i mid-stream with 3 items pending → valid_o, data_o, read_pointer_o go to 0 asynchronously. After the joint reset release, new traffic starts at slot 0.
